// File: rtl/multiplier_evaluator_if.sv
// rtl/multiplier_evaluator_if.sv - control, candidate operand/product and score bundle of multiplier_evaluator
// Optional first-fail members are present only when EVAL_FIRST_FAIL_EN is defined.
interface multiplier_evaluator_if #(
  parameter int WIDTH = 2
);
  logic                 start;
  logic                 abort;
  logic [WIDTH-1:0]     a_o;
  logic [WIDTH-1:0]     b_o;
  logic [2*WIDTH-1:0]   p_i;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH:0]     err_cnt;
  logic [2*WIDTH+3:0]   ham_sum;
  logic                 pass;
`ifdef EVAL_FIRST_FAIL_EN
  logic                 fail_valid;
  logic [WIDTH-1:0]     fail_a;
  logic [WIDTH-1:0]     fail_b;
  logic [2*WIDTH-1:0]   fail_p;

  modport master (
    output start, abort, p_i,
    input  a_o, b_o, busy, done, err_cnt, ham_sum, pass,
    input  fail_valid, fail_a, fail_b, fail_p
  );
  modport slave (
    input  start, abort, p_i,
    output a_o, b_o, busy, done, err_cnt, ham_sum, pass,
    output fail_valid, fail_a, fail_b, fail_p
  );
`else
  modport master (
    output start, abort, p_i,
    input  a_o, b_o, busy, done, err_cnt, ham_sum, pass
  );
  modport slave (
    input  start, abort, p_i,
    output a_o, b_o, busy, done, err_cnt, ham_sum, pass
  );
`endif
endinterface

// File: rtl/multiplier_evaluator.sv
// rtl/multiplier_evaluator.sv - exhaustive sweep scorer for a candidate multiplier (error count, Hamming sum)
// Define EVAL_FIRST_FAIL_EN to add capture of the first mismatching vector.
module multiplier_evaluator #(
  parameter int WIDTH = 2,
  parameter int LAT   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  multiplier_evaluator_if.slave  bus
);
  localparam int PW = 2 * WIDTH;
  localparam int EW = PW + 1;
  localparam int HW = PW + 4;
  localparam logic [1:0] LAT_L = 2'(LAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  logic [PW-1:0]    vcnt;
  logic [1:0]       dcnt;
  logic             flush;
  logic             start_acc;
  logic             last_vec;

  logic             busy;
  logic             done;
  logic [WIDTH-1:0] a_drv;
  logic [WIDTH-1:0] b_drv;

  logic             al_vld;
  logic [PW-1:0]    al_idx;
  logic [PW-1:0]    al_exp;

  logic             cmp_vld;
  logic [PW-1:0]    cmp_p;
  logic [PW-1:0]    cmp_exp;
  logic [PW-1:0]    cmp_diff;
  logic             cmp_miss;

  logic [EW-1:0]    err_q;
  logic [HW-1:0]    ham_q;

  function automatic logic [HW-1:0] popcount(input logic [PW-1:0] x);
    logic [HW-1:0] n;
    n = '0;
    for (int i = 0; i < PW; i++) begin
      n = n + HW'(x[i]);
    end
    return n;
  endfunction

  assign flush     = (state != S_IDLE) && bus.abort;
  assign start_acc = (state == S_IDLE) && bus.start && !bus.abort;
  assign last_vec  = (vcnt == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start_acc) state_nx = S_SWEEP;
        S_SWEEP: if (last_vec) state_nx = S_DRAIN;
        S_DRAIN: if (dcnt == LAT_L) state_nx = S_DONE;
        S_DONE:  state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    a_drv = '0;
    b_drv = '0;
    case (state)
      S_SWEEP: begin
        busy  = 1'b1;
        a_drv = vcnt[WIDTH-1:0];
        b_drv = vcnt[PW-1:WIDTH];
      end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || state != S_SWEEP) begin
      vcnt <= '0;
    end else begin
      vcnt <= vcnt + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state != S_DRAIN) begin
      dcnt <= '0;
    end else begin
      dcnt <= dcnt + 2'd1;
    end
  end

  // The issued index rides a LAT-deep delay line so it meets p_i from the same vector.
  generate
    if (LAT == 0) begin : g_nolat
      assign al_vld = (state == S_SWEEP);
      assign al_idx = vcnt;
    end else begin : g_lat
      logic          vld_sr [LAT];
      logic [PW-1:0] idx_sr [LAT];

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          for (int i = 0; i < LAT; i++) begin
            vld_sr[i] <= 1'b0;
            idx_sr[i] <= '0;
          end
        end else begin
          vld_sr[0] <= (state == S_SWEEP);
          idx_sr[0] <= vcnt;
          for (int i = 1; i < LAT; i++) begin
            vld_sr[i] <= vld_sr[i-1];
            idx_sr[i] <= idx_sr[i-1];
          end
        end
      end

      assign al_vld = vld_sr[LAT-1];
      assign al_idx = idx_sr[LAT-1];
    end
  endgenerate

  assign al_exp = PW'(al_idx[WIDTH-1:0]) * PW'(al_idx[PW-1:WIDTH]);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cmp_vld <= 1'b0;
      cmp_p   <= '0;
      cmp_exp <= '0;
    end else begin
      cmp_vld <= al_vld;
      cmp_p   <= bus.p_i;
      cmp_exp <= al_exp;
    end
  end

  assign cmp_diff = cmp_p ^ cmp_exp;
  assign cmp_miss = cmp_vld && (cmp_diff != '0);

  always_ff @(posedge clk) begin
    if (rst || flush || start_acc) begin
      err_q <= '0;
      ham_q <= '0;
    end else if (cmp_miss) begin
      err_q <= err_q + EW'(1);
      ham_q <= ham_q + popcount(cmp_diff);
    end
  end

  assign bus.a_o     = a_drv;
  assign bus.b_o     = b_drv;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.err_cnt = err_q;
  assign bus.ham_sum = ham_q;
  assign bus.pass    = (err_q == '0);

`ifdef EVAL_FIRST_FAIL_EN
  logic [PW-1:0] cmp_idx;
  logic          ff_vld;
  logic [PW-1:0] ff_idx;
  logic [PW-1:0] ff_p;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cmp_idx <= '0;
    end else begin
      cmp_idx <= al_idx;
    end
  end

  // Only the first miss of a sweep is kept; later ones leave the capture alone.
  always_ff @(posedge clk) begin
    if (rst || flush || start_acc) begin
      ff_vld <= 1'b0;
      ff_idx <= '0;
      ff_p   <= '0;
    end else if (cmp_miss && !ff_vld) begin
      ff_vld <= 1'b1;
      ff_idx <= cmp_idx;
      ff_p   <= cmp_p;
    end
  end

  assign bus.fail_valid = ff_vld;
  assign bus.fail_a     = ff_idx[WIDTH-1:0];
  assign bus.fail_b     = ff_idx[PW-1:WIDTH];
  assign bus.fail_p     = ff_p;
`endif
endmodule

// File: tb/tb_multiplier_evaluator.sv
// tb/tb_multiplier_evaluator.sv - self-checking bench for multiplier_evaluator (LAT=0 and LAT=2 instances)
module tb_multiplier_evaluator;
  localparam int NV = 16;

  typedef struct {
    bit s;
    int mode;
    int dcyc;
    int err;
    int ham;
    int fv;
    int fa;
    int fb;
    int fp;
  } vec_t;

  logic clk;
  logic rst;
  logic start_v;
  logic abort_v;
  bit   sel;
  int   mode;
  int   nchk;
  int   nerr;
  logic [3:0] mask [NV];

  logic [3:0] ga, gb, ca, cb;
  logic [3:0] pa1, pa2, pb1, pb2;

  logic       s_busy, s_done, s_pass;
  logic [1:0] s_a, s_b;
  logic [4:0] s_err;
  logic [7:0] s_ham;

  multiplier_evaluator_if #(.WIDTH(2)) ifa ();
  multiplier_evaluator_if #(.WIDTH(2)) ifb ();

  multiplier_evaluator #(.WIDTH(2), .LAT(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  multiplier_evaluator #(.WIDTH(2), .LAT(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ifa.start = start_v & ~sel;
  assign ifa.abort = abort_v & ~sel;
  assign ifb.start = start_v & sel;
  assign ifb.abort = abort_v & sel;

  // Candidates: mode 0 golden, 1 stuck-zero, 2 MSB flipped, 3 random mask, 4 two-stage golden on the LAT=0 unit
  always_comb begin
    ga = {2'b00, ifa.a_o} * {2'b00, ifa.b_o};
    gb = {2'b00, ifb.a_o} * {2'b00, ifb.b_o};
    case (mode)
      1: begin ca = 4'd0; cb = 4'd0; end
      2: begin ca = ga ^ 4'b1000; cb = gb ^ 4'b1000; end
      3: begin ca = ga ^ mask[{ifa.b_o, ifa.a_o}]; cb = gb ^ mask[{ifb.b_o, ifb.a_o}]; end
      default: begin ca = ga; cb = gb; end
    endcase
  end

  always @(posedge clk) begin
    pa1 <= ga;
    pa2 <= pa1;
    pb1 <= cb;
    pb2 <= pb1;
  end

  assign ifa.p_i = (mode == 4) ? pa2 : ca;
  assign ifb.p_i = pb2;

  always_comb begin
    s_busy = sel ? ifb.busy    : ifa.busy;
    s_done = sel ? ifb.done    : ifa.done;
    s_pass = sel ? ifb.pass    : ifa.pass;
    s_a    = sel ? ifb.a_o     : ifa.a_o;
    s_b    = sel ? ifb.b_o     : ifa.b_o;
    s_err  = sel ? ifb.err_cnt : ifa.err_cnt;
    s_ham  = sel ? ifb.ham_sum : ifa.ham_sum;
  end

`ifdef EVAL_FIRST_FAIL_EN
  logic       s_fv;
  logic [1:0] s_fa, s_fb;
  logic [3:0] s_fp;
  always_comb begin
    s_fv = sel ? ifb.fail_valid : ifa.fail_valid;
    s_fa = sel ? ifb.fail_a     : ifa.fail_a;
    s_fb = sel ? ifb.fail_b     : ifa.fail_b;
    s_fp = sel ? ifb.fail_p     : ifa.fail_p;
  end
`endif

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Score of the random-mask candidate, straight from the definition of the sweep
  task automatic model(output int e, output int h, output int fv, output int fa, output int fb, output int fp);
    int x;
    e = 0; h = 0; fv = 0; fa = 0; fb = 0; fp = 0;
    for (int v = 0; v < NV; v++) begin
      x = int'(mask[v]);
      if (x != 0) begin
        if (fv == 0) begin
          fv = 1;
          fa = v % 4;
          fb = v / 4;
          fp = ((v % 4) * (v / 4)) ^ x;
        end
        e++;
        h += $countones(x);
      end
    end
  endtask

  task automatic run_sweep(input bit s, output int dcyc);
    sel = s;
    @(negedge clk);
    start_v = 1'b1;
    dcyc = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start_v = 1'b0;
      if (s_done) begin
        dcyc = c;
        break;
      end
      if (c <= NV) begin
        chk("sweep_busy", int'(s_busy), 1);
        chk("sweep_a", int'(s_a), (c - 1) % 4);
        chk("sweep_b", int'(s_b), (c - 1) / 4);
      end
    end
    if (dcyc < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic check_result(input vec_t t, input int dcyc);
    chk("done_cycle", dcyc, t.dcyc);
    chk("busy_at_done", int'(s_busy), 0);
    chk("err_cnt", int'(s_err), t.err);
    chk("ham_sum", int'(s_ham), t.ham);
    chk("pass", int'(s_pass), (t.err == 0) ? 1 : 0);
`ifdef EVAL_FIRST_FAIL_EN
    chk("fail_valid", int'(s_fv), t.fv);
    if (t.fv != 0) begin
      chk("fail_a", int'(s_fa), t.fa);
      chk("fail_b", int'(s_fb), t.fb);
      chk("fail_p", int'(s_fp), t.fp);
    end
`endif
    @(negedge clk);
    chk("done_one_cycle", int'(s_done), 0);
    chk("err_held", int'(s_err), t.err);
    chk("ham_held", int'(s_ham), t.ham);
    chk("a_idle", int'(s_a), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    vec_t rv;
    int   d, e, h, fv, fa, fb, fp, dfirst;

    nchk = 0; nerr = 0;
    rst = 1'b1; start_v = 1'b0; abort_v = 1'b0; sel = 1'b0; mode = 0;
    for (int v = 0; v < NV; v++) mask[v] = 4'd0;

    tbl[0] = '{0, 0, 18, 0,  0,  0, 0, 0, 0};
    tbl[1] = '{0, 1, 18, 9,  14, 1, 1, 1, 0};
    tbl[2] = '{0, 2, 18, 16, 16, 1, 0, 0, 8};
    tbl[3] = '{1, 0, 20, 0,  0,  0, 0, 0, 0};
    tbl[4] = '{1, 1, 20, 9,  14, 1, 1, 1, 0};

    repeat (3) @(negedge clk);
    chk("rst_a_o", int'(ifa.a_o), 0);
    chk("rst_b_o", int'(ifa.b_o), 0);
    chk("rst_busy", int'(ifa.busy), 0);
    chk("rst_done", int'(ifa.done), 0);
    chk("rst_err", int'(ifa.err_cnt), 0);
    chk("rst_ham", int'(ifa.ham_sum), 0);
    chk("rst_pass", int'(ifa.pass), 1);
    chk("rst_b_busy", int'(ifb.busy), 0);
    chk("rst_b_pass", int'(ifb.pass), 1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      mode = tbl[i].mode;
      run_sweep(tbl[i].s, d);
      check_result(tbl[i], d);
    end

    for (int r = 0; r < 6; r++) begin
      for (int v = 0; v < NV; v++)
        mask[v] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      mode = 3;
      model(e, h, fv, fa, fb, fp);
      rv = '{(r % 2) == 1, 3, ((r % 2) == 1) ? 20 : 18, e, h, fv, fa, fb, fp};
      run_sweep(rv.s, d);
      check_result(rv, d);
    end

    mode = 4;
    run_sweep(1'b0, d);
    chk("reg_cand_lat0_done", d, 18);
    chk("reg_cand_lat0_err_nonzero", int'(s_err != 5'd0), 1);
    @(negedge clk);

    // Extra start while busy, abort, then restart
    mode = 2; sel = 1'b0; dfirst = -1;
    @(negedge clk);
    start_v = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (s_done && dfirst < 0) dfirst = c;
      if (c == 5) begin
        chk("ignored_start_a", int'(s_a), 0);
        chk("ignored_start_b", int'(s_b), 1);
      end
      if (c == 6) chk("pre_abort_err", int'(s_err), 4);
      if (c == 7) begin
        chk("abort_busy", int'(s_busy), 0);
        chk("abort_err", int'(s_err), 0);
        chk("abort_ham", int'(s_ham), 0);
`ifdef EVAL_FIRST_FAIL_EN
        chk("abort_fail_valid", int'(s_fv), 0);
`endif
      end
      if (c == 9) chk("restart_busy", int'(s_busy), 1);
      if (c == 26) begin
        chk("restart_err", int'(s_err), 16);
        chk("restart_ham", int'(s_ham), 16);
      end
      start_v = (c == 4 || c == 8);
      abort_v = (c == 6);
    end
    chk("abort_restart_done_cycle", dfirst, 26);
    start_v = 1'b0; abort_v = 1'b0;

    // Reset mid-sweep, then start+abort together in IDLE
    mode = 2;
    @(negedge clk);
    start_v = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 10) chk("pre_rst_busy", int'(s_busy), 1);
      if (c == 11) begin
        chk("mid_rst_a_o", int'(s_a), 0);
        chk("mid_rst_b_o", int'(s_b), 0);
        chk("mid_rst_busy", int'(s_busy), 0);
        chk("mid_rst_done", int'(s_done), 0);
        chk("mid_rst_err", int'(s_err), 0);
        chk("mid_rst_ham", int'(s_ham), 0);
        chk("mid_rst_pass", int'(s_pass), 1);
`ifdef EVAL_FIRST_FAIL_EN
        chk("mid_rst_fail_valid", int'(s_fv), 0);
`endif
      end
      if (c == 13 || c == 14 || c == 15) chk("start_abort_busy", int'(s_busy), 0);
      start_v = (c == 12);
      abort_v = (c == 12);
      rst     = (c == 10);
    end
    start_v = 1'b0; abort_v = 1'b0; rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
